fila_cmd_in: RTL and testbench

- Front-end command stage for the fila queue.
- Conditions two raw push-buttons and an 8-bit switch bank into clean single-cycle enqueue/dequeue commands with associated data.
- Checks the queue length fed back from fila and suppresses commands that would overflow or underflow it.
- Sits directly upstream of fila: drives its data_in, enqueue_in and dequeue_in, and consumes its len_out.

---
 rtl/fila_pkg.sv | 13 +
 rtl/fila_debounce.sv | 41 ++++
 rtl/fila_cmd_in.sv | 113 +++++++++++
 tb/tb_fila_cmd_in.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
// Shared constants and types for the fila queue and its command front end.
package fila_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SETTLE = 2'd2
   } state_t;

endpackage

// File: rtl/fila_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// registered single-cycle pulse on each accepted rising level.
module fila_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic rise
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // A new level is accepted on its DEBOUNCE_CYCLES-th consecutive differing sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= 2'b00;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         rise <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync[1];
            cnt   <= '0;
            rise  <= sync[1];
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fila_cmd_in.sv
// Command front end for fila: debounced buttons become single-cycle enqueue /
// dequeue commands, refused when they would overflow or underflow the queue.
module fila_cmd_in
   import fila_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 200
) (
   input  logic              clk_10KHz,
   input  logic              reset,
   input  logic              btn_enq_in,
   input  logic              btn_deq_in,
   input  logic [DATA_W-1:0] sw_data_in,
   input  logic [DATA_W-1:0] len_in,
   output logic [DATA_W-1:0] data_out,
   output logic              enqueue_out,
   output logic              dequeue_out,
   output logic              rej_out
);

   localparam logic [DATA_W-1:0] LEN_FULL = DATA_W'(DEPTH);

   logic req_enq;
   logic req_deq;

   fila_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enq (
      .clk   (clk_10KHz),
      .rst_n (reset),
      .raw   (btn_enq_in),
      .rise  (req_enq)
   );

   fila_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_deq (
      .clk   (clk_10KHz),
      .rst_n (reset),
      .raw   (btn_deq_in),
      .rise  (req_deq)
   );

   state_t            state;
   state_t            state_nxt;
   logic              pend_enq;
   logic              pend_deq;
   logic              pend_enq_nxt;
   logic              pend_deq_nxt;
   logic              want_enq;
   logic              want_deq;
   logic [DATA_W-1:0] data_nxt;
   logic              enq_nxt;
   logic              deq_nxt;
   logic              rej_nxt;

   // A request arriving this cycle is serviced as if already pending.
   assign want_enq = pend_enq | req_enq;
   assign want_deq = pend_deq | req_deq;

   // State, pending flags and registered command outputs.
   always_ff @(posedge clk_10KHz or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pend_enq    <= 1'b0;
         pend_deq    <= 1'b0;
         data_out    <= '0;
         enqueue_out <= 1'b0;
         dequeue_out <= 1'b0;
         rej_out     <= 1'b0;
      end else begin
         state       <= state_nxt;
         pend_enq    <= pend_enq_nxt;
         pend_deq    <= pend_deq_nxt;
         data_out    <= data_nxt;
         enqueue_out <= enq_nxt;
         dequeue_out <= deq_nxt;
         rej_out     <= rej_nxt;
      end
   end

   // Next state: one command, then two quiet cycles so len_in catches up.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (want_enq || want_deq) state_nxt = ISSUE;
         ISSUE:   state_nxt = SETTLE;
         SETTLE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command decode; enqueue wins when both are pending.
   always_comb begin
      pend_enq_nxt = want_enq;
      pend_deq_nxt = want_deq;
      data_nxt     = data_out;
      enq_nxt      = 1'b0;
      deq_nxt      = 1'b0;
      rej_nxt      = 1'b0;
      if (state == IDLE) begin
         if (want_enq) begin
            pend_enq_nxt = 1'b0;
            if (len_in < LEN_FULL) begin
               enq_nxt  = 1'b1;
               data_nxt = sw_data_in;
            end else begin
               rej_nxt = 1'b1;
            end
         end else if (want_deq) begin
            pend_deq_nxt = 1'b0;
            if (len_in != '0) deq_nxt = 1'b1;
            else              rej_nxt = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fila_cmd_in.sv
// Directed bench for fila_cmd_in with DEBOUNCE_CYCLES=4 and a simple fila length model.
module tb_fila_cmd_in;
   import fila_pkg::*;

   localparam int WIN = 30;

   logic              clk;
   logic              reset;
   logic              btn_enq_in;
   logic              btn_deq_in;
   logic [DATA_W-1:0] sw_data_in;
   logic [DATA_W-1:0] len_in;
   logic [DATA_W-1:0] data_out;
   logic              enqueue_out;
   logic              dequeue_out;
   logic              rej_out;

   fila_cmd_in #(.DEBOUNCE_CYCLES(4)) dut (
      .clk_10KHz   (clk),
      .reset       (reset),
      .btn_enq_in  (btn_enq_in),
      .btn_deq_in  (btn_deq_in),
      .sw_data_in  (sw_data_in),
      .len_in      (len_in),
      .data_out    (data_out),
      .enqueue_out (enqueue_out),
      .dequeue_out (dequeue_out),
      .rej_out     (rej_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         enq_hold;
      int         deq_hold;
      logic [7:0] sw;
      logic [7:0] len0;
      int         exp_enq_edge;
      int         exp_deq_edge;
      int         exp_rej_edge;
      logic [7:0] exp_data;
      logic [7:0] exp_len;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int multi_hot = 0;

   int fe, fd, fr;
   int ce, cd, cr;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // One clock: fila model updates length from the command seen during the cycle.
   task automatic tick();
      logic e, d;
      e = enqueue_out;
      d = dequeue_out;
      @(posedge clk);
      #1;
      if (e && len_in < 8'(DEPTH)) len_in = len_in + 8'd1;
      if (d && len_in != 8'd0)     len_in = len_in - 8'd1;
      if (32'(enqueue_out) + 32'(dequeue_out) + 32'(rej_out) > 1) multi_hot++;
   endtask

   task automatic observe(input int e);
      if (enqueue_out) begin ce++; if (fe == 0) fe = e; end
      if (dequeue_out) begin cd++; if (fd == 0) fd = e; end
      if (rej_out)     begin cr++; if (fr == 0) fr = e; end
   endtask

   // Raw buttons are high for the first <hold> sampling edges of the window.
   task automatic run_window(input int enq_hold, input int deq_hold);
      fe = 0; fd = 0; fr = 0; ce = 0; cd = 0; cr = 0;
      btn_enq_in = (enq_hold > 0);
      btn_deq_in = (deq_hold > 0);
      for (int e = 1; e <= WIN; e++) begin
         tick();
         observe(e);
         btn_enq_in = (e < enq_hold);
         btn_deq_in = (e < deq_hold);
      end
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{10,  0, 8'h11, 8'd0, 7,  0, 0, 8'h11, 8'd1};
      vecs[1] = '{ 0, 10, 8'h11, 8'd1, 0,  7, 0, 8'h11, 8'd0};
      vecs[2] = '{10,  0, 8'h55, 8'd8, 0,  0, 7, 8'h11, 8'd8};
      vecs[3] = '{ 0, 10, 8'h55, 8'd0, 0,  0, 7, 8'h11, 8'd0};
      vecs[4] = '{10, 10, 8'h99, 8'd1, 7, 10, 0, 8'h99, 8'd1};
      vecs[5] = '{ 3,  0, 8'h33, 8'd2, 0,  0, 0, 8'h99, 8'd2};
      vecs[6] = '{ 4,  0, 8'h22, 8'd2, 7,  0, 0, 8'h22, 8'd3};
      vecs[7] = '{ 0, 10, 8'h22, 8'd8, 0,  7, 0, 8'h22, 8'd7};
      vecs[8] = '{10,  0, 8'h7e, 8'd7, 7,  0, 0, 8'h7e, 8'd8};

      // Reset held with a button already down.
      reset      = 1'b0;
      btn_enq_in = 1'b1;
      btn_deq_in = 1'b0;
      sw_data_in = 8'h5a;
      len_in     = 8'd0;
      for (int i = 0; i < 3; i++) tick();
      chk("reset_data",  32'(data_out), 0);
      chk("reset_enq",   32'(enqueue_out), 0);
      chk("reset_deq",   32'(dequeue_out), 0);
      chk("reset_rej",   32'(rej_out), 0);
      reset = 1'b1;
      run_window(10, 0);
      chk("held_enq_edge", fe, 7);
      chk("held_enq_cnt",  ce, 1);
      chk("held_other",    cd + cr, 0);
      chk("held_data",     32'(data_out), 32'h5a);
      chk("held_len",      32'(len_in), 1);

      foreach (vecs[i]) begin
         sw_data_in = vecs[i].sw;
         len_in     = vecs[i].len0;
         run_window(vecs[i].enq_hold, vecs[i].deq_hold);
         chk($sformatf("v%0d_enq_edge", i), fe, vecs[i].exp_enq_edge);
         chk($sformatf("v%0d_deq_edge", i), fd, vecs[i].exp_deq_edge);
         chk($sformatf("v%0d_rej_edge", i), fr, vecs[i].exp_rej_edge);
         chk($sformatf("v%0d_enq_cnt", i),  ce, (vecs[i].exp_enq_edge != 0) ? 1 : 0);
         chk($sformatf("v%0d_deq_cnt", i),  cd, (vecs[i].exp_deq_edge != 0) ? 1 : 0);
         chk($sformatf("v%0d_rej_cnt", i),  cr, (vecs[i].exp_rej_edge != 0) ? 1 : 0);
         chk($sformatf("v%0d_data", i),     32'(data_out), 32'(vecs[i].exp_data));
         chk($sformatf("v%0d_len", i),      32'(len_in), 32'(vecs[i].exp_len));
      end

      // Bouncy dequeue: 2-sample toggles for 12 edges, then a stable hold.
      len_in = 8'd3;
      fe = 0; fd = 0; fr = 0; ce = 0; cd = 0; cr = 0;
      btn_deq_in = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         tick();
         observe(e);
         if (e + 1 <= 12) btn_deq_in = (((e) / 2) % 2) == 0;
         else             btn_deq_in = (e + 1 <= 22);
      end
      chk("bounce_deq_edge", fd, 19);
      chk("bounce_deq_cnt",  cd, 1);
      chk("bounce_other",    ce + cr, 0);
      chk("bounce_len",      32'(len_in), 2);

      // Reset asserted while an enqueue pulse is on the outputs.
      len_in     = 8'd0;
      sw_data_in = 8'h44;
      btn_enq_in = 1'b1;
      begin
         int seen;
         seen = 0;
         for (int e = 1; e <= 20 && seen == 0; e++) begin
            tick();
            if (enqueue_out) seen = e;
         end
         chk("midrst_pulse_edge", seen, 7);
      end
      #1 reset = 1'b0;
      #1;
      chk("midrst_enq_cut", 32'(enqueue_out), 0);
      chk("midrst_data_clr", 32'(data_out), 0);
      btn_enq_in = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b1;
      run_window(0, 0);
      chk("midrst_no_cmds", ce + cd + cr, 0);
      chk("midrst_len", 32'(len_in), 0);

      chk("one_hot_outputs", multi_hot, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
